// File: rtl/cpu_mem_bus_pkg.sv
// Shared CPU package: memory-map regions, T-cycle phases, DMA control states and decode helpers.
package cpu_mem_bus_pkg;

    typedef enum logic [2:0] {
        RegionCart,
        RegionVram,
        RegionWram,
        RegionOam,
        RegionUnused,
        RegionIo,
        RegionHram
    } mem_region_e;

    typedef enum logic [1:0] {
        DmaIdle,
        DmaStart,
        DmaCopy
    } dma_state_e;

    localparam logic [15:0] VRAM_BASE    = 16'h8000;
    localparam logic [15:0] CART_HI_BASE = 16'hA000;
    localparam logic [15:0] WRAM_BASE    = 16'hC000;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [15:0] UNUSED_BASE  = 16'hFEA0;
    localparam logic [15:0] IO_BASE      = 16'hFF00;
    localparam logic [15:0] HRAM_BASE    = 16'hFF80;
    localparam logic [15:0] IE_ADDR      = 16'hFFFF;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

    localparam logic [1:0] TCYC_LATCH   = 2'd0;
    localparam logic [1:0] TCYC_BUS     = 2'd1;
    localparam logic [1:0] TCYC_CAPTURE = 2'd2;
    localparam logic [1:0] TCYC_RETIRE  = 2'd3;

    localparam logic [7:0] OPEN_BUS       = 8'hFF;
    localparam logic [7:0] DMA_LAST_INDEX = 8'd159;
    localparam logic [7:0] ECHO_PAGE      = 8'hE0;

    function automatic mem_region_e decode_region(input logic [15:0] addr);
        if (addr < VRAM_BASE)         return RegionCart;
        else if (addr < CART_HI_BASE) return RegionVram;
        else if (addr < WRAM_BASE)    return RegionCart;
        else if (addr < OAM_BASE)     return RegionWram;
        else if (addr < UNUSED_BASE)  return RegionOam;
        else if (addr < IO_BASE)      return RegionUnused;
        else if (addr < HRAM_BASE)    return RegionIo;
        else if (addr == IE_ADDR)     return RegionIo;
        else                          return RegionHram;
    endfunction

    // Pages E0-FF alias WRAM (echo), so the DMA reads from page S-0x20 instead.
    function automatic logic [7:0] dma_page(input logic [7:0] src);
        return (src >= ECHO_PAGE) ? src - 8'h20 : src;
    endfunction

endpackage

// File: rtl/cpu_mem_bus_oam_dma.sv
// OAM DMA engine: 160 M-cycle copy from page S into OAM, one idle M-cycle after being armed.
module oam_dma
    import cpu_mem_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  t_cycle,
    input  logic        arm,
    input  logic [7:0]  arm_src,
    input  logic [7:0]  ext_rdata,
    output logic        dma_active,
    output logic        copy_active,
    output logic [15:0] dma_addr,
    output logic [7:0]  src,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata
);

    dma_state_e state;
    dma_state_e state_next;
    logic [7:0] count;
    logic [7:0] data;
    logic       m_end;

    assign m_end = (t_cycle == TCYC_RETIRE);

    always_ff @(posedge clk) begin
        if (reset) state <= DmaIdle;
        else       state <= state_next;
    end

    // All transitions happen at M-cycle boundaries; a new arm always wins.
    always_comb begin
        state_next = state;
        if (m_end) begin
            if (arm) begin
                state_next = DmaStart;
            end else begin
                case (state)
                    DmaStart: state_next = DmaCopy;
                    DmaCopy:  if (count == DMA_LAST_INDEX) state_next = DmaIdle;
                    default:  state_next = state;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src   <= '0;
            count <= '0;
            data  <= '0;
        end else begin
            if (state == DmaCopy && t_cycle == TCYC_CAPTURE) data <= ext_rdata;
            if (m_end) begin
                if (arm) begin
                    src   <= arm_src;
                    count <= '0;
                end else if (state == DmaCopy) begin
                    count <= (count == DMA_LAST_INDEX) ? '0 : count + 8'd1;
                end
            end
        end
    end

    always_comb begin
        dma_active  = (state != DmaIdle);
        copy_active = (state == DmaCopy);
        oam_we      = copy_active && m_end;
        oam_addr    = count;
        oam_wdata   = data;
        dma_addr    = {dma_page(src), count};
    end

endmodule

// File: rtl/cpu_mem_bus.sv
// CPU memory bus: region decode, T-cycle sequencing, inline HRAM.
// Optional OAM DMA engine enabled by defining CPU_MEM_BUS_DMA_EN.
module cpu_mem_bus
    import cpu_mem_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  t_cycle,
    input  logic        mem_enable,
    input  logic        mem_write,
    input  logic [15:0] mem_addr,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  mem_rdata,
    output logic        ext_enable,
    output logic        ext_write,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    output mem_region_e ext_region,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        dma_active
);

    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    mem_region_e req_region;
    logic [7:0]  hram [0:126];
    logic        bus_phase;
    logic        cpu_ext;
    logic        dma_copy;
    logic [15:0] dma_addr;
    logic [7:0]  rd_value;

`ifdef CPU_MEM_BUS_DMA_EN
    logic       dma_arm;
    logic [7:0] dma_src;

    // FF46 writes arm the engine even while it runs; the data still goes downstream when idle.
    assign dma_arm = req_valid && req_write && (req_addr == DMA_REG_ADDR);

    oam_dma u_oam_dma (
        .clk         (clk),
        .reset       (reset),
        .t_cycle     (t_cycle),
        .arm         (dma_arm),
        .arm_src     (req_wdata),
        .ext_rdata   (ext_rdata),
        .dma_active  (dma_active),
        .copy_active (dma_copy),
        .dma_addr    (dma_addr),
        .src         (dma_src),
        .oam_we      (oam_we),
        .oam_addr    (oam_addr),
        .oam_wdata   (oam_wdata)
    );
`else
    assign dma_active = 1'b0;
    assign dma_copy   = 1'b0;
    assign dma_addr   = '0;
    assign oam_we     = 1'b0;
    assign oam_addr   = '0;
    assign oam_wdata  = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            req_valid  <= 1'b0;
            req_write  <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_region <= RegionCart;
        end else if (t_cycle == TCYC_LATCH) begin
            req_valid <= mem_enable;
            if (mem_enable) begin
                req_write  <= mem_write;
                req_addr   <= mem_addr;
                req_wdata  <= mem_wdata;
                req_region <= decode_region(mem_addr);
            end
        end else if (t_cycle == TCYC_RETIRE) begin
            req_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && req_valid && req_write && req_region == RegionHram
            && t_cycle == TCYC_CAPTURE)
            hram[req_addr[6:0]] <= req_wdata;
    end

    always_comb begin
        rd_value = OPEN_BUS;
        if (req_region == RegionHram)
            rd_value = hram[req_addr[6:0]];
`ifdef CPU_MEM_BUS_DMA_EN
        else if (req_addr == DMA_REG_ADDR)
            rd_value = dma_src;
`endif
        else if (!dma_active && req_region != RegionUnused)
            rd_value = ext_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset)
            mem_rdata <= OPEN_BUS;
        else if (req_valid && !req_write && t_cycle == TCYC_CAPTURE)
            mem_rdata <= rd_value;
    end

    always_comb begin
        bus_phase  = (t_cycle == TCYC_BUS) || (t_cycle == TCYC_CAPTURE);
        cpu_ext    = req_valid && !dma_active
                     && req_region != RegionHram && req_region != RegionUnused;
        ext_enable = bus_phase && (cpu_ext || dma_copy);
        ext_write  = bus_phase && cpu_ext && req_write;
        ext_addr   = dma_copy ? dma_addr : req_addr;
        ext_wdata  = req_wdata;
        ext_region = dma_copy ? decode_region(dma_addr) : req_region;
    end

endmodule

// File: doc/cpu_mem_bus.md
CPU_MEM_BUS -- requirements
Module: cpu_mem_bus

Interface
REQ-001 clk  input  1  system clock, rising-edge.
REQ-002 reset  input  1  reset, synchronous, active-high.
REQ-003 t_cycle  input  2  T-cycle phase 0..3 within the CPU M-cycle.
REQ-004 mem_enable, mem_write  input  1 each  CPU access request and direction, valid during t_cycle 0.
REQ-005 mem_addr  input  16  CPU address; mem_wdata  input  8  CPU write data.
REQ-006 mem_rdata  output  8  read data returned to CPU, registered.
REQ-007 ext_enable, ext_write  output  1 each  downstream access strobe and direction.
REQ-008 ext_addr  output  16; ext_wdata  output  8; ext_rdata  input  8; ext_region  output  mem_region_e.
REQ-009 oam_we  output  1; oam_addr  output  8; oam_wdata  output  8  dedicated DMA write port.
REQ-010 dma_active  output  1  high while a DMA transfer is in progress.

Function
REQ-011 Decode: 0000-7FFF and A000-BFFF=RegionCart; 8000-9FFF=RegionVram; C000-FDFF=RegionWram; FE00-FE9F=RegionOam; FEA0-FEFF=RegionUnused; FF00-FF7F and FFFF=RegionIo; FF80-FFFE=RegionHram.
REQ-012 Request latched at the end of t_cycle 0 when mem_enable=1; no request means no downstream activity that M-cycle.
REQ-013 Non-HRAM, non-unused access: ext_enable=1 during t_cycle 1 and 2 with latched addr/region/wdata; ext_write=1 only for writes.
REQ-014 Read data captured from ext_rdata at end of t_cycle 2; mem_rdata valid throughout t_cycle 3 (CPU samples at t_cycle 3).
REQ-015 HRAM: internal 127x8 storage; write committed at end of t_cycle 2; read data presented in t_cycle 3; never drives ext bus.
REQ-016 RegionUnused: reads return 0xFF, writes dropped, no ext strobe.
REQ-017 mem_rdata holds its previous value in M-cycles without a read.
REQ-018 Access with mem_enable deasserted after t_cycle 0 still completes (latched request governs).

Reset
REQ-019 On reset: mem_rdata=0xFF, ext_enable=0, ext_write=0, ext_addr=0, ext_wdata=0, oam_we=0, oam_addr=0, oam_wdata=0, dma_active=0, DMA source register=0x00, DMA counter=0.
REQ-020 Reset mid-access or mid-DMA aborts immediately; HRAM contents not cleared.

Configuration
REQ-021 Macro CPU_MEM_BUS_DMA_EN: defined -> OAM DMA engine per REQ-022..027 present; undefined -> FF46 is an ordinary RegionIo address, oam_* and dma_active tied 0.
REQ-022 CPU write to FF46 stores value S (still forwarded to ext bus), and arms DMA; reads of FF46 return S, not ext_rdata.
REQ-023 DMA states: Idle -> Start (one full M-cycle delay) -> Copy (160 M-cycles) -> Idle; dma_active=1 in Start and Copy.
REQ-024 Copy M-cycle n (0..159): ext read of S*256+n during t_cycle 1-2 with ext_region from decode; oam_we=1 in t_cycle 3 with oam_addr=n, oam_wdata=captured byte.
REQ-025 During Start/Copy, CPU accesses outside HRAM: reads return 0xFF, writes dropped, no ext strobe; HRAM accesses serviced normally.
REQ-026 Write to FF46 while dma_active: restart to Start with new source, counter reset to 0.
REQ-027 Source S >= 0xE0 maps to S-0x20 (WRAM echo), arithmetic 8-bit.

Structure
REQ-028 mem_region_e enum and region boundary constants in the shared CPU package beside the other control enums.
REQ-029 DMA engine in one sub-module, oam_dma, instantiated only under CPU_MEM_BUS_DMA_EN; HRAM inline.

Verification
REQ-030 Read 0x0150, ext_rdata=0x3E -> ext_enable t1-t2, region Cart, mem_rdata=0x3E at t3.
REQ-031 Write 0x5A to 0xFF80, then read 0xFF80 -> mem_rdata=0x5A, ext_enable never asserted.
REQ-032 Read 0xFEA5 -> mem_rdata=0xFF, no ext strobe; write 0x12 to 0xFEA5 -> no effect.
REQ-033 DMA_EN: write 0xC1 to FF46 -> dma_active 1 M-cycle later, 160 oam_we pulses addr 0x00..0x9F from 0xC100..0xC19F, dma_active=0 after; CPU read 0xC000 during DMA returns 0xFF.
REQ-034 DMA_EN: write 0xC2 to FF46 at copy index 50 -> restart, next oam_addr sequence begins at 0x00 from 0xC200.
REQ-035 Assert reset at DMA index 10 -> dma_active=0, oam_we=0, mem_rdata=0xFF next cycle.
